datapath_sequencer: RTL and testbench
=====================================

# datapath_sequencer

Multi-cycle control unit that drives the register-file/ALU/RAM datapath from a stream of commands. Each accepted command is decoded into the datapath control word: register selects, write strobes, function select, carry-in and writeback mux select. It is sequenced over one or more cycles and reported complete with a single-cycle `done` pulse. ALU status is latched into a flags register, so a carry-chained add can use the carry from the previous ALU command.

## Interface
Parameters:
- `FS_XOR`, `5'b00110`: ALU function code used by CLR (r XOR r = 0).

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept; high only in IDLE.
- `cmd_op`  in  3  000 NOP, 001 ALU, 010 LOAD, 011 STORE, 100 CLR, 101 ALUC, 110/111 illegal.
- `cmd_rd`  in  5  destination register.
- `cmd_ra`  in  5  source A / RAM address register.
- `cmd_rb`  in  5  source B / store-data register.
- `cmd_fs`  in  5  ALU function select.
- `cmd_cin`  in  1  carry-in for ALU op.
- `SIGNAL`  in  4  ALU status {V,C,N,Z}.
- `A`  out  5  register read select A.
- `B`  out  5  register read select B.
- `regSel`  out  5  register write select.
- `wrt`  out  1  register write enable.
- `FS`  out  5  ALU function select.
- `CO`  out  1  ALU carry-in.
- `RAMwrt`  out  1  RAM write enable.
- `muxSelect`  out  1  writeback source: 0 ALU, 1 RAM.
- `flags`  out  4  latched {V,C,N,Z}.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle illegal-op pulse, coincident with `done`.

## Operation
- Handshake: a command is accepted on a rising edge where `cmd_valid && cmd_ready`. All `cmd_*` fields are latched at that edge, and later changes on them are ignored.
- States: IDLE, EXEC, LD_ADDR, LD_WB, ST, CLR, FIN.
- IDLE drives idle values: `A=B=regSel=FS=0`, `wrt=RAMwrt=CO=muxSelect=0`.
- NOP: IDLE→FIN. No strobes.
- ALU: IDLE→EXEC→FIN.
  - EXEC drives `A=ra, B=rb, FS=fs, CO=cin, regSel=rd, wrt=1, muxSelect=0`.
  - `flags<=SIGNAL` on the EXEC exit edge.
- ALUC: same as ALU, except `CO=flags[2]`, using the flags value at accept time.
- LOAD: IDLE→LD_ADDR→LD_WB→FIN.
  - LD_ADDR drives `A=ra, muxSelect=1, wrt=0, RAMwrt=0`.
  - LD_WB holds `A=ra, muxSelect=1` and adds `regSel=rd, wrt=1`.
  - Flags are unchanged.
- STORE: IDLE→ST→FIN. ST drives `A=ra, B=rb, RAMwrt=1, wrt=0`. Flags are unchanged.
- CLR: 5-bit counter `i` runs from 0 to 31.
  - Each CLR cycle drives `A=B=regSel=i, FS=FS_XOR, CO=0, wrt=1, muxSelect=0`.
  - The state leaves CLR on the edge where `i==31`. The counter then returns to 0.
  - `flags<=0` on exit.
- Illegal op: IDLE→FIN with `err=1` in FIN. No strobes, flags unchanged.
- FIN: `done=1`, `cmd_ready=0`, all controls at idle values. FIN→IDLE unconditionally.

## Timing
- Reset (async, `reset==0`) forces IDLE, `i=0`, `flags=0`, all outputs at idle values, and `done=err=0`. `cmd_ready` rises to 1 one edge after reset deasserts.
- Reset mid-command aborts the command. No `done` is issued. If reset hits inside EXEC, LD_WB or CLR, the write strobe drops immediately and the write is lost.
- All outputs are registered and decoded from state only. No combinational path from `cmd_*` to any datapath control.
- Cycles from accept edge to `done` high: NOP/illegal 1, ALU/ALUC 2, STORE 2, LOAD 3, CLR 33.
- The next command can be accepted no earlier than the edge after FIN. Minimum spacing is therefore 2 cycles for NOP/illegal.
- `cmd_valid` held with no acceptance has no effect. Commands are not queued.

## Test plan
- Reset then idle: hold `reset=0` mid-CLR at `i=10` → `wrt=0` immediately, `flags=0`, no `done`. After release, `cmd_ready=1` one edge later.
- ALU op rd=3, ra=1, rb=2, fs=2, cin=1, `SIGNAL=4'b0100` → EXEC lasts exactly one cycle with `A=1, B=2, regSel=3, wrt=1, CO=1`. `done` follows the next cycle and `flags=4'b0100`.
- ALUC right after that ALU op → `CO=1`. With flags 0 → `CO=0`. `cmd_cin` is ignored in both cases.
- LOAD rd=7, ra=5 → one cycle `muxSelect=1, wrt=0`, then one cycle `wrt=1, regSel=7`. `done` rises 3 cycles after accept and flags are unchanged.
- STORE ra=4, rb=9 → exactly one cycle with `RAMwrt=1, A=4, B=9, wrt=0`.
- CLR → 32 consecutive write cycles with `regSel` 0..31 and `FS=FS_XOR`, then `done`. Illegal op 110 → `done` and `err` pulse together 1 cycle after accept, with no strobes.

Source files
------------

// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer for the register-file/ALU/RAM datapath.
// Decodes one command at a time into a registered control word and pulses done on completion.
module datapath_sequencer #(
    parameter logic [4:0] FS_XOR = 5'b00110
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [4:0] cmd_rd,
    input  logic [4:0] cmd_ra,
    input  logic [4:0] cmd_rb,
    input  logic [4:0] cmd_fs,
    input  logic       cmd_cin,
    input  logic [3:0] SIGNAL,
    output logic [4:0] A,
    output logic [4:0] B,
    output logic [4:0] regSel,
    output logic       wrt,
    output logic [4:0] FS,
    output logic       CO,
    output logic       RAMwrt,
    output logic       muxSelect,
    output logic [3:0] flags,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_ALU   = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_CLR   = 3'b100;
    localparam logic [2:0] OP_ALUC  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_LD_ADDR, S_LD_WB, S_ST, S_CLR, S_FIN
    } state_t;

    state_t     state, state_nx;
    logic [4:0] i, i_nx;
    logic       accept;

    logic [4:0] rd_q, ra_q, rb_q, fs_q;
    logic       cin_q;
    logic [4:0] rd_e, ra_e, rb_e, fs_e;
    logic       cin_e;

    logic [4:0] a_nx, b_nx, rsel_nx, fs_nx;
    logic       wrt_nx, co_nx, ramwrt_nx, mux_nx, done_nx, err_nx, ready_nx;

    // cmd_ready is only ever high while in IDLE, so it alone qualifies acceptance.
    assign accept = cmd_valid && cmd_ready;

    // ALUC resolves its carry at accept time from the flags that are current then.
    assign rd_e  = accept ? cmd_rd : rd_q;
    assign ra_e  = accept ? cmd_ra : ra_q;
    assign rb_e  = accept ? cmd_rb : rb_q;
    assign fs_e  = accept ? cmd_fs : fs_q;
    assign cin_e = accept ? ((cmd_op == OP_ALUC) ? flags[2] : cmd_cin) : cin_q;

    always_ff @(posedge clock) begin
        if (accept) begin
            rd_q  <= cmd_rd;
            ra_q  <= cmd_ra;
            rb_q  <= cmd_rb;
            fs_q  <= cmd_fs;
            cin_q <= (cmd_op == OP_ALUC) ? flags[2] : cmd_cin;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            i     <= '0;
        end else begin
            state <= state_nx;
            i     <= i_nx;
        end
    end

    always_comb begin
        state_nx = state;
        i_nx     = i;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_NOP:           state_nx = S_FIN;
                        OP_ALU, OP_ALUC:  state_nx = S_EXEC;
                        OP_LOAD:          state_nx = S_LD_ADDR;
                        OP_STORE:         state_nx = S_ST;
                        OP_CLR: begin
                            state_nx = S_CLR;
                            i_nx     = '0;
                        end
                        default:          state_nx = S_FIN;
                    endcase
                end
            end
            S_EXEC:    state_nx = S_FIN;
            S_LD_ADDR: state_nx = S_LD_WB;
            S_LD_WB:   state_nx = S_FIN;
            S_ST:      state_nx = S_FIN;
            S_CLR: begin
                if (i == 5'd31) begin
                    state_nx = S_FIN;
                    i_nx     = '0;
                end else begin
                    i_nx = i + 5'd1;
                end
            end
            default:   state_nx = S_IDLE;
        endcase
    end

    // Control word is decoded from the next state and registered, so outputs change only on edges.
    always_comb begin
        a_nx      = '0;
        b_nx      = '0;
        rsel_nx   = '0;
        fs_nx     = '0;
        wrt_nx    = 1'b0;
        co_nx     = 1'b0;
        ramwrt_nx = 1'b0;
        mux_nx    = 1'b0;
        done_nx   = 1'b0;
        err_nx    = 1'b0;
        ready_nx  = 1'b0;
        case (state_nx)
            S_IDLE: ready_nx = 1'b1;
            S_EXEC: begin
                a_nx    = ra_e;
                b_nx    = rb_e;
                rsel_nx = rd_e;
                fs_nx   = fs_e;
                co_nx   = cin_e;
                wrt_nx  = 1'b1;
            end
            S_LD_ADDR: begin
                a_nx   = ra_e;
                mux_nx = 1'b1;
            end
            S_LD_WB: begin
                a_nx    = ra_e;
                rsel_nx = rd_e;
                mux_nx  = 1'b1;
                wrt_nx  = 1'b1;
            end
            S_ST: begin
                a_nx      = ra_e;
                b_nx      = rb_e;
                ramwrt_nx = 1'b1;
            end
            S_CLR: begin
                a_nx    = i_nx;
                b_nx    = i_nx;
                rsel_nx = i_nx;
                fs_nx   = FS_XOR;
                wrt_nx  = 1'b1;
            end
            S_FIN: begin
                done_nx = 1'b1;
                // Only an illegal op reaches FIN straight from an accept with err set.
                err_nx  = (state == S_IDLE) && (cmd_op[2:1] == 2'b11);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            A         <= '0;
            B         <= '0;
            regSel    <= '0;
            FS        <= '0;
            wrt       <= 1'b0;
            CO        <= 1'b0;
            RAMwrt    <= 1'b0;
            muxSelect <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            A         <= a_nx;
            B         <= b_nx;
            regSel    <= rsel_nx;
            FS        <= fs_nx;
            wrt       <= wrt_nx;
            CO        <= co_nx;
            RAMwrt    <= ramwrt_nx;
            muxSelect <= mux_nx;
            done      <= done_nx;
            err       <= err_nx;
            cmd_ready <= ready_nx;
        end
    end

    // ALU status is captured as the single EXEC cycle ends; CLR leaves the flags zeroed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flags <= '0;
        end else if (state == S_EXEC) begin
            flags <= SIGNAL;
        end else if (state == S_CLR && i == 5'd31) begin
            flags <= '0;
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: expected control words and completions are queued
// by the stimulus and consumed by a monitor whenever the DUT strobes or pulses done.
module tb_datapath_sequencer;

    localparam logic [4:0] FS_XOR = 5'b00110;

    logic       clock;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [4:0] cmd_rd, cmd_ra, cmd_rb, cmd_fs;
    logic       cmd_cin;
    logic [3:0] SIGNAL;
    logic [4:0] A, B, regSel, FS;
    logic       wrt, CO, RAMwrt, muxSelect, done, err;
    logic [3:0] flags;

    datapath_sequencer #(.FS_XOR(FS_XOR)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .cmd_fs(cmd_fs), .cmd_cin(cmd_cin), .SIGNAL(SIGNAL),
        .A(A), .B(B), .regSel(regSel), .wrt(wrt), .FS(FS), .CO(CO),
        .RAMwrt(RAMwrt), .muxSelect(muxSelect), .flags(flags), .done(done), .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       err;
        logic [3:0] flg;
        int         lat;
    } done_t;

    logic [23:0] exp_ctl[$];
    done_t       exp_done[$];
    int          errors = 0;
    int          checks = 0;
    int          edge_cnt = 0;
    int          acc_edge = 0;

    logic [23:0] act_ctl;
    assign act_ctl = {A, B, regSel, wrt, FS, CO, RAMwrt, muxSelect};

    function automatic logic [23:0] mk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] rs,
                                       input logic w, input logic [4:0] f, input logic co,
                                       input logic ram, input logic mux);
        return {a, b, rs, w, f, co, ram, mux};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_done(input logic e, input logic [3:0] f, input int lat);
        done_t d;
        d.err = e;
        d.flg = f;
        d.lat = lat;
        exp_done.push_back(d);
    endtask

    always @(posedge clock) begin
        edge_cnt++;
        if (reset && cmd_valid && cmd_ready) acc_edge = edge_cnt;
    end

    // Monitor: every strobe cycle and every done pulse consumes one queued expectation.
    always @(negedge clock) begin
        if (reset) begin
            if (wrt || RAMwrt || muxSelect) begin
                if (exp_ctl.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: ctl=%h expected no strobe", act_ctl);
                end else begin
                    check("ctl_word", 32'(act_ctl), 32'(exp_ctl.pop_front()));
                end
            end else begin
                check("idle_ctl", 32'(act_ctl), 32'd0);
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 expected 0");
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    check("done_err", 32'(err), 32'(d.err));
                    check("done_flags", 32'(flags), 32'(d.flg));
                    check("done_latency", 32'(edge_cnt - acc_edge + 1), 32'(d.lat));
                end
            end else begin
                check("err_without_done", 32'(err), 32'd0);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] ra,
                         input logic [4:0] rb, input logic [4:0] fs, input logic cin);
        int k;
        k = 0;
        @(negedge clock);
        while (!cmd_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: cmd_ready=0 expected 1");
        end
        cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_fs = fs; cmd_cin = cin;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        // Scramble the fields after accept; the DUT must use its latched copy.
        cmd_rd = 5'h1f; cmd_ra = 5'h1e; cmd_rb = 5'h1d; cmd_fs = 5'h15; cmd_cin = ~cin;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (exp_done.size() != 0 && k < 100) begin
            @(negedge clock);
            k++;
        end
        if (exp_done.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: pending=%0d expected 0", exp_done.size());
            exp_done.delete();
            exp_ctl.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0;
        cmd_rb = '0; cmd_fs = '0; cmd_cin = 1'b0; SIGNAL = '0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_ctl", 32'(act_ctl), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("ready_before_edge", 32'(cmd_ready), 32'd0);
        @(posedge clock);
        #1;
        check("ready_after_edge", 32'(cmd_ready), 32'd1);

        // ALU: carry-in from the command, flags captured from SIGNAL.
        SIGNAL = 4'b0100;
        exp_ctl.push_back(mk(5'd1, 5'd2, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0));
        push_done(1'b0, 4'b0100, 2);
        issue(3'b001, 5'd3, 5'd1, 5'd2, 5'd2, 1'b1);
        wait_done();

        // ALUC with C=1 in flags; cmd_cin=0 ignored.
        SIGNAL = 4'b0000;
        exp_ctl.push_back(mk(5'd5, 5'd6, 5'd4, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0));
        push_done(1'b0, 4'b0000, 2);
        issue(3'b101, 5'd4, 5'd5, 5'd6, 5'd1, 1'b0);
        wait_done();

        // ALUC with flags 0; cmd_cin=1 ignored.
        SIGNAL = 4'b1011;
        exp_ctl.push_back(mk(5'd9, 5'd10, 5'd8, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0));
        push_done(1'b0, 4'b1011, 2);
        issue(3'b101, 5'd8, 5'd9, 5'd10, 5'd3, 1'b1);
        wait_done();

        // LOAD: address cycle, then writeback cycle; flags untouched.
        SIGNAL = 4'b0100;
        exp_ctl.push_back(mk(5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1));
        exp_ctl.push_back(mk(5'd5, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1));
        push_done(1'b0, 4'b1011, 3);
        issue(3'b010, 5'd7, 5'd5, 5'd3, 5'd4, 1'b1);
        wait_done();

        // STORE
        exp_ctl.push_back(mk(5'd4, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0));
        push_done(1'b0, 4'b1011, 2);
        issue(3'b011, 5'd2, 5'd4, 5'd9, 5'd7, 1'b1);
        wait_done();

        // NOP and both illegal encodings.
        push_done(1'b0, 4'b1011, 1);
        issue(3'b000, 5'd1, 5'd2, 5'd3, 5'd4, 1'b1);
        wait_done();
        push_done(1'b1, 4'b1011, 1);
        issue(3'b110, 5'd1, 5'd2, 5'd3, 5'd4, 1'b1);
        wait_done();
        push_done(1'b1, 4'b1011, 1);
        issue(3'b111, 5'd6, 5'd7, 5'd8, 5'd9, 1'b0);
        wait_done();

        // CLR: 32 XOR self-writes, then flags cleared.
        SIGNAL = 4'b1111;
        for (int k = 0; k < 32; k++)
            exp_ctl.push_back(mk(5'(k), 5'(k), 5'(k), 1'b1, FS_XOR, 1'b0, 1'b0, 1'b0));
        push_done(1'b0, 4'b0000, 33);
        issue(3'b100, 5'd3, 5'd3, 5'd3, 5'd3, 1'b1);
        wait_done();

        SIGNAL = 4'b0100;
        exp_ctl.push_back(mk(5'd2, 5'd3, 5'd1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0));
        push_done(1'b0, 4'b0100, 2);
        issue(3'b001, 5'd1, 5'd2, 5'd3, 5'd9, 1'b0);
        wait_done();

        // Reset in the middle of CLR at i=10.
        for (int k = 0; k < 32; k++)
            exp_ctl.push_back(mk(5'(k), 5'(k), 5'(k), 1'b1, FS_XOR, 1'b0, 1'b0, 1'b0));
        push_done(1'b0, 4'b0000, 33);
        issue(3'b100, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (10) @(posedge clock);
        #1;
        check("clr_i10_sel", 32'(regSel), 32'd10);
        check("clr_i10_wrt", 32'(wrt), 32'd1);
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_wrt", 32'(wrt), 32'd0);
        check("midrst_flags", 32'(flags), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd0);
        check("midrst_ctl", 32'(act_ctl), 32'd0);
        exp_ctl.delete();
        exp_done.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        check("rel_ready_before", 32'(cmd_ready), 32'd0);
        @(posedge clock);
        #1;
        check("rel_ready_after", 32'(cmd_ready), 32'd1);

        // Recovery after the aborted command.
        SIGNAL = 4'b0010;
        exp_ctl.push_back(mk(5'd7, 5'd8, 5'd6, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0));
        push_done(1'b0, 4'b0010, 2);
        issue(3'b001, 5'd6, 5'd7, 5'd8, 5'd5, 1'b1);
        wait_done();

        repeat (3) @(negedge clock);
        check("ctl_queue_drained", 32'(exp_ctl.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
